// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit direction
// counter encodings and the saturating counter update.
package bp_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] r_res;
        r_res = ctr;
        if (taken) begin
            if (ctr != ST) r_res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) r_res = ctr - 2'd1;
        end
        return r_res;
    endfunction

endpackage

// File: rtl/btb_ram.sv
// Direct-mapped BTB storage: two async read ports (fetch lookup, EX training), one sync write port.
// Reads return pre-write contents in the write cycle; valid/ctr clear asynchronously on rst.
module btb_ram
    import bp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd0_idx,
    output logic             o_rd0_valid,
    output logic [TAG_W-1:0] o_rd0_tag,
    output logic [XLEN-1:0]  o_rd0_target,
    output logic [1:0]       o_rd0_ctr,
    input  logic [IDX_W-1:0] i_rd1_idx,
    output logic             o_rd1_valid,
    output logic [TAG_W-1:0] o_rd1_tag,
    output logic [XLEN-1:0]  o_rd1_target,
    output logic [1:0]       o_rd1_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [XLEN-1:0]  i_wr_target,
    input  logic [1:0]       i_wr_ctr
);

    logic             r_valid  [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [XLEN-1:0]  r_target [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= WNT;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_ctr[i_wr_idx]   <= i_wr_ctr;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en && !rst) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    assign o_rd0_valid  = r_valid[i_rd0_idx];
    assign o_rd0_tag    = r_tag[i_rd0_idx];
    assign o_rd0_target = r_target[i_rd0_idx];
    assign o_rd0_ctr    = r_ctr[i_rd0_idx];

    assign o_rd1_valid  = r_valid[i_rd1_idx];
    assign o_rd1_tag    = r_tag[i_rd1_idx];
    assign o_rd1_target = r_target[i_rd1_idx];
    assign o_rd1_ctr    = r_ctr[i_rd1_idx];

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch PC generation with BTB + 2-bit direction prediction, EX-driven training and redirect.
// Prediction is 0-cycle from if_pc; stall holds the PC unless a mispredict redirects it.
module branch_predict_fetch
    import bp_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_upd_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;

    logic             w_if_valid;
    logic [TAG_W-1:0] w_if_ent_tag;
    logic [XLEN-1:0]  w_if_ent_target;
    logic [1:0]       w_if_ent_ctr;
    logic             w_ex_valid;
    logic [TAG_W-1:0] w_ex_ent_tag;
    logic [XLEN-1:0]  w_ex_ent_target;
    logic [1:0]       w_ex_ent_ctr;

    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_pred_taken;
    logic [XLEN-1:0]  w_pred_target;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_ex_pc_plus4;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_next_pc;

    logic             w_wr_en;
    logic [XLEN-1:0]  w_wr_target;
    logic [1:0]       w_wr_ctr;

    logic             w_unused;

    assign w_if_idx = r_pc[IDX_W+1:2];
    assign w_if_tag = r_pc[XLEN-1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

    btb_ram #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_rd0_idx    (w_if_idx),
        .o_rd0_valid  (w_if_valid),
        .o_rd0_tag    (w_if_ent_tag),
        .o_rd0_target (w_if_ent_target),
        .o_rd0_ctr    (w_if_ent_ctr),
        .i_rd1_idx    (w_ex_idx),
        .o_rd1_valid  (w_ex_valid),
        .o_rd1_tag    (w_ex_ent_tag),
        .o_rd1_target (w_ex_ent_target),
        .o_rd1_ctr    (w_ex_ent_ctr),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_ex_idx),
        .i_wr_tag     (w_ex_tag),
        .i_wr_target  (w_wr_target),
        .i_wr_ctr     (w_wr_ctr)
    );

    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_ex_pc_plus4 = ex_pc + XLEN'(4);

    assign w_if_hit      = w_if_valid && (w_if_ent_tag == w_if_tag);
    assign w_pred_taken  = w_if_hit && w_if_ent_ctr[1];
    assign w_pred_target = w_if_hit ? w_if_ent_target : w_pc_plus4;

    // A taken branch with the right direction can still mispredict on a stale target.
    assign w_mispredict = ex_upd_valid &&
                          ((ex_taken != ex_pred_taken) ||
                           (ex_taken && (ex_target != ex_pred_target)));

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_mispredict) begin
            w_next_pc = ex_taken ? ex_target : w_ex_pc_plus4;
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    assign w_ex_hit = w_ex_valid && (w_ex_ent_tag == w_ex_tag);

    // Not-taken misses leave the BTB alone so fall-through code does not evict real branches.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = w_ex_ent_target;
        w_wr_ctr    = w_ex_ent_ctr;
        if (ex_upd_valid) begin
            if (w_ex_hit) begin
                w_wr_en  = 1'b1;
                w_wr_ctr = ctr_next(w_ex_ent_ctr, ex_taken);
                if (ex_taken) w_wr_target = ex_target;
            end else if (ex_taken) begin
                w_wr_en     = 1'b1;
                w_wr_ctr    = WT;
                w_wr_target = ex_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (ex_upd_valid) r_branch_cnt  <= r_branch_cnt + CNT_W'(1);
            if (w_mispredict) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign w_unused = ^ex_pc[1:0];

    assign if_pc       = r_pc;
    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_target;
    assign flush       = w_mispredict;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Bench for branch_predict_fetch: directed scenarios then random traffic,
// each cycle compared against a table-based model of the predictor rules.
module tb_branch_predict_fetch;

    localparam int          XLEN  = 64;
    localparam int          D     = 16;
    localparam int          IDX   = 4;
    localparam int          CNT_W = 32;
    localparam logic [63:0] RPC   = 64'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic [XLEN-1:0]   if_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              ex_upd_valid = 1'b0;
    logic [XLEN-1:0]   ex_pc = '0;
    logic              ex_taken = 1'b0;
    logic [XLEN-1:0]   ex_target = '0;
    logic              ex_pred_taken = 1'b0;
    logic [XLEN-1:0]   ex_pred_target = '0;
    logic              flush;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [63:0] m_pc;
    bit          m_valid  [D];
    logic [63:0] m_tag    [D];
    logic [63:0] m_target [D];
    int          m_ctr    [D];
    int          m_bcnt;
    int          m_mcnt;

    branch_predict_fetch #(
        .XLEN      (XLEN),
        .BTB_DEPTH (D),
        .RESET_PC  (RPC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_upd_valid   (ex_upd_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [63:0] pc);
        return int'((pc / 4) % D);
    endfunction

    function automatic logic [63:0] m_tagof(input logic [63:0] pc);
        return pc / (4 * D);
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_ptaken(input logic [63:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_ptarget(input logic [63:0] pc);
        return m_hit(pc) ? m_target[m_idx(pc)] : pc + 64'd4;
    endfunction

    task automatic m_reset();
        m_pc = RPC;
        m_bcnt = 0;
        m_mcnt = 0;
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    // One cycle: drive, check at the falling edge, advance the model, cross the rising edge.
    task automatic step(input bit s, input bit u, input logic [63:0] p, input bit t,
                        input logic [63:0] tg, input bit pt, input logic [63:0] ptg);
        bit          mis;
        logic [63:0] npc;
        int          ix;
        stall = s; ex_upd_valid = u; ex_pc = p; ex_taken = t;
        ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
        @(negedge clk);
        mis = u && ((t != pt) || (t && tg != ptg));
        chk("if_pc", if_pc, m_pc);
        chk("pred_taken", 64'(pred_taken), 64'(m_ptaken(m_pc)));
        chk("pred_target", pred_target, m_ptarget(m_pc));
        chk("flush", 64'(flush), 64'(mis));
        chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));
        if (mis)                npc = t ? tg : p + 64'd4;
        else if (s)             npc = m_pc;
        else if (m_ptaken(m_pc)) npc = m_ptarget(m_pc);
        else                    npc = m_pc + 64'd4;
        if (u) begin
            m_bcnt++;
            if (mis) m_mcnt++;
            ix = m_idx(p);
            if (m_hit(p)) begin
                if (t) begin
                    m_ctr[ix]    = (m_ctr[ix] == 3) ? 3 : m_ctr[ix] + 1;
                    m_target[ix] = tg;
                end else begin
                    m_ctr[ix] = (m_ctr[ix] == 0) ? 0 : m_ctr[ix] - 1;
                end
            end else if (t) begin
                m_valid[ix]  = 1'b1;
                m_tag[ix]    = m_tagof(p);
                m_target[ix] = tg;
                m_ctr[ix]    = 2;
            end
        end
        m_pc = npc;
        @(posedge clk);
        #1;
    endtask

    // Redirect fetch to pc via a not-taken resolution that was predicted taken.
    task automatic go_to(input logic [63:0] pc);
        step(0, 1, pc - 64'd4, 0, 64'd0, 1, 64'd0);
    endtask

    initial begin
        logic [63:0] hold_pc;
        logic [63:0] a;
        logic [63:0] rp;
        logic [63:0] pool [5];
        logic [63:0] tpool [4];
        bit          rt;

        pool[0] = 64'h100; pool[1] = 64'h140; pool[2] = 64'h104;
        pool[3] = 64'h180; pool[4] = 64'h108;
        tpool[0] = 64'h100; tpool[1] = 64'h200; tpool[2] = 64'h240; tpool[3] = 64'h104;

        // reset state
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_if_pc", if_pc, RPC);
        chk("rst_pred_taken", 64'(pred_taken), 64'd0);
        chk("rst_pred_target", pred_target, RPC + 64'd4);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();

        // sequential fetch
        for (int i = 0; i < 3; i++) step(0, 0, 64'd0, 0, 64'd0, 0, 64'd0);
        chk("seq_pc", if_pc, 64'hC);

        // loop training at 0x10 -> 0x0
        step(0, 1, 64'h10, 1, 64'h0, 0, 64'h14);
        chk("loop_flush1", 64'(flush), 64'd1);
        chk("loop_redirect", if_pc, 64'h0);
        chk("loop_mcnt1", 64'(mispred_cnt), 64'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 64'd0, 0, 64'd0, 0, 64'd0);
        chk("loop_at", if_pc, 64'h10);
        chk("loop_pred_taken", 64'(pred_taken), 64'd1);
        chk("loop_pred_target", pred_target, 64'h0);
        step(0, 1, 64'h10, 1, 64'h0, 1, 64'h0);
        chk("loop_flush2", 64'(flush), 64'd0);

        // saturation at 0x20
        for (int i = 0; i < 4; i++) step(0, 1, 64'h20, 1, 64'h300, 0, 64'h24);
        step(0, 1, 64'h20, 0, 64'h0, 1, 64'h300);
        go_to(64'h20);
        chk("sat_pred_taken", 64'(pred_taken), 64'd1);
        chk("sat_pred_target", pred_target, 64'h300);
        step(0, 1, 64'h20, 0, 64'h0, 1, 64'h300);
        step(0, 1, 64'h20, 0, 64'h0, 1, 64'h300);
        go_to(64'h20);
        chk("sat_pred_nt", 64'(pred_taken), 64'd0);
        chk("sat_pred_nt_target", pred_target, 64'h300);

        // aliasing entries evict each other
        for (int k = 0; k < 4; k++) begin
            a = (k % 2 == 1) ? 64'h20 : 64'h20 + 64'(4 * D);
            step(0, 1, a, 1, 64'h400 + 64'(k * 8), m_ptaken(a), m_ptarget(a));
            chk("alias_flush", 64'(flush), 64'd1);
        end

        // stall + mispredict: mispredict wins
        step(1, 1, 64'h40, 0, 64'h0, 1, 64'h80);
        chk("stmis_flush", 64'(flush), 64'd1);
        chk("stmis_pc", if_pc, 64'h44);

        // stall alone, then async reset mid-stall
        hold_pc = if_pc;
        for (int i = 0; i < 3; i++) step(1, 0, 64'd0, 0, 64'd0, 0, 64'd0);
        chk("stall_pc", if_pc, hold_pc);
        rst = 1'b1;
        #1;
        chk("arst_pc", if_pc, RPC);
        chk("arst_bcnt", 64'(branch_cnt), 64'd0);
        chk("arst_mcnt", 64'(mispred_cnt), 64'd0);
        chk("arst_pred", 64'(pred_taken), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall = 1'b0;
        m_reset();
        step(0, 0, 64'd0, 0, 64'd0, 0, 64'd0);

        // PC wrap
        go_to(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pred_target", pred_target, 64'h0);
        step(0, 0, 64'd0, 0, 64'd0, 0, 64'd0);
        chk("wrap_pc", if_pc, 64'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rp = ($urandom_range(0, 7) == 0) ? {$urandom(), $urandom() & 32'hFFFF_FFFC}
                                             : pool[$urandom_range(0, 4)];
            rt = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1)
                step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rp, rt,
                     tpool[$urandom_range(0, 3)], m_ptaken(rp), m_ptarget(rp));
            else
                step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rp, rt,
                     tpool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                     tpool[$urandom_range(0, 3)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_fetch.md
# branch_predict_fetch

Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces the always-predict-not-taken PC update of the 5-stage pipeline. It supplies the fetch PC plus a predicted next PC to instruction memory and the IF/ID register. It takes resolved branch/jump outcomes from the execute stage to train the BTB and redirect on mispredict.

## Interface
- XLEN, 64, address/PC width
- BTB_DEPTH, 16, BTB entries; power of 2, ≥2
- RESET_PC, 0, PC loaded on reset
- CNT_W, 32, width of performance counters

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit load-use stall: hold PC
- if_pc  out  XLEN  current fetch address
- pred_taken  out  1  prediction for if_pc (travels down pipe)
- pred_target  out  XLEN  predicted target for if_pc
- ex_upd_valid  in  1  EX resolved a branch/JAL this cycle
- ex_pc  in  XLEN  PC of resolved instruction
- ex_taken  in  1  actual direction
- ex_target  in  XLEN  actual taken target
- ex_pred_taken  in  1  prediction carried with instruction
- ex_pred_target  in  XLEN  predicted target carried with instruction
- flush  out  1  kill IF/ID and ID/EX contents
- branch_cnt  out  CNT_W  resolved branches since reset
- mispred_cnt  out  CNT_W  mispredicts since reset

## Operation
- IDX = log2(BTB_DEPTH); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup (combinational on if_pc): hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = hit ? entry.target : if_pc+4.
- mispredict = ex_upd_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)); flush = mispredict.
- Next PC priority: mispredict → (ex_taken ? ex_target : ex_pc+4); else stall → hold; else pred_taken → pred_target; else if_pc+4.
- Training on ex_upd_valid, entry at ex_pc index:
  - hit, taken: ctr saturating +1 (max 2'b11), target ← ex_target.
  - hit, not taken: ctr saturating −1 (min 2'b00), target unchanged.
  - miss, taken: allocate/overwrite: valid=1, tag, target=ex_target, ctr=2'b10.
  - miss, not taken: no write.
- Counters: branch_cnt +1 per ex_upd_valid; mispred_cnt +1 per mispredict; both wrap modulo 2^CNT_W.
- PC arithmetic modulo 2^XLEN; if_pc+4 wraps from all-ones region to 0 without error.

## Timing
- Reset (async assert, sync-safe deassert): if_pc=RESET_PC, all valid=0, all ctr=2'b01, counters=0; pred_taken=0, pred_target=RESET_PC+4, flush=0.
- Prediction: 0-cycle, combinational from if_pc.
- Redirect: flush high in mispredict cycle; if_pc = corrected PC after next rising edge.
- BTB write takes effect at rising edge; lookup of same index in same cycle returns pre-write contents.
- mispredict and stall together: mispredict wins, PC redirects.
- ex_upd_valid low: no BTB write, no counter change, flush=0.
- rst mid-operation: all state discarded immediately, including pending training.

## Structure
- Package bp_pkg: XLEN default, counter encodings SNT=00, WNT=01, WT=10, ST=11, function ctr_next(ctr, taken) with saturation.
- Sub-module btb_ram: BTB_DEPTH-entry array, async read port, sync write port, async clear of valid/ctr on rst.
- Top: PC register, next-PC mux, mispredict compare, performance counters.

## Test plan
- Reset: rst pulse → if_pc=0, pred_taken=0, pred_target=4, counters 0; sequential fetch 0,4,8,… without stall.
- Loop training: branch at 0x10 to 0x0 resolved taken twice → first a mispredict (flush=1, next if_pc=0x0, mispred_cnt=1), then fetch of 0x10 predicts taken, target 0x0, second resolution no flush.
- Saturation: four taken then one not-taken at 0x20 → ctr 11 then 10, still predicts taken; two more not-taken → predicts not taken.
- Alias: 0x20 and 0x20+4·BTB_DEPTH alternate taken → each allocation evicts the other; every resolution mispredicts.
- Stall+mispredict: stall=1 with mispredict at ex_pc=0x40 not taken (predicted taken) → if_pc=0x44 next cycle, flush=1.
- Stall alone 3 cycles → if_pc constant, counters unchanged; async rst mid-stall → if_pc=RESET_PC same cycle.
